// File: rtl/matrix_pkg.sv
// Shared constants, state type and element helpers for the packed-matrix stream blocks.
package matrix_pkg;

  localparam int MAT_N  = 8;
  localparam int ELEM_W = 32;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  // Bit offset of element (r,c) inside a row-major packed matrix bus.
  function automatic int elem_offset(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

  // Negate a sign-extended w-bit value; -2^(w-1) saturates to 2^(w-1)-1.
  function automatic logic [63:0] sat_neg(input logic [63:0] x, input int w);
    logic [63:0] min_v;
    min_v = ~64'd0 << (w - 1);
    if (x == min_v) return ~min_v;
    return -x;
  endfunction

endpackage

// File: rtl/matrix_stream_tx_if.sv
// Packed-matrix input and element-serial output bundle of matrix_stream_tx.
interface matrix_stream_tx_if #(
  parameter int N = matrix_pkg::MAT_N,
  parameter int W = matrix_pkg::ELEM_W
);
  localparam int RC_W = $clog2(N);

  logic                in_valid;
  logic                in_ready;
  logic [N*N*W-1:0]    real_in;
  logic [N*N*W-1:0]    imag_in;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_real;
  logic [W-1:0]        out_imag;
  logic [RC_W-1:0]     out_row;
  logic [RC_W-1:0]     out_col;
  logic                out_last;
  logic                busy;

  modport master (
    output in_valid, real_in, imag_in, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_row, out_col, out_last, busy
  );

  modport slave (
    input  in_valid, real_in, imag_in, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_row, out_col, out_last, busy
  );

endinterface

// File: rtl/matrix_elem_mux.sv
// Combinational N*N-to-1 element select from the packed matrix buffer.
module matrix_elem_mux
  import matrix_pkg::*;
#(
  parameter int N    = MAT_N,
  parameter int W    = ELEM_W,
  parameter int RC_W = $clog2(N)
) (
  input  logic [N*N*W-1:0] real_buf_i,
  input  logic [N*N*W-1:0] imag_buf_i,
  input  logic [RC_W-1:0]  row_i,
  input  logic [RC_W-1:0]  col_i,
  output logic [W-1:0]     real_o,
  output logic [W-1:0]     imag_o
);

  localparam int IDX_W = $clog2(N * N);

  logic [W-1:0]     real_arr [N*N];
  logic [W-1:0]     imag_arr [N*N];
  logic [IDX_W-1:0] idx;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign real_arr[r*N+c] = real_buf_i[elem_offset(r, c, N, W) +: W];
      assign imag_arr[r*N+c] = imag_buf_i[elem_offset(r, c, N, W) +: W];
    end
  end

  assign idx    = IDX_W'(row_i * N + col_i);
  assign real_o = real_arr[idx];
  assign imag_o = imag_arr[idx];

endmodule

// File: rtl/matrix_stream_tx.sv
// Captures one packed N x N complex matrix and streams it row-major, one element per beat,
// optionally lower-triangle only and/or conjugated.
module matrix_stream_tx
  import matrix_pkg::*;
#(
  parameter int N        = MAT_N,
  parameter int W        = ELEM_W,
  parameter int TRI_ONLY = 0,
  parameter int CONJ     = 0
) (
  input logic               clk,
  input logic               rst,
  matrix_stream_tx_if.slave bus
);

  localparam int RC_W = $clog2(N);

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [RC_W-1:0]  row_q, col_q;
  logic [W-1:0]     real_q, imag_q;
  logic [N*N*W-1:0] real_buf_q, imag_buf_q;

  logic             accept, xfer;
  logic [RC_W-1:0]  row_d, col_d;
  logic             last_d;
  logic [W-1:0]     mux_real, mux_imag;
  logic [W-1:0]     real_d, sel_imag, imag_d;

  assign accept = (state_q == IDLE) && in_ready_q && bus.in_valid;
  assign xfer   = out_valid_q && bus.out_ready;

  // The index of the element presented after this edge: (0,0) on accept, else the successor.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      row_d = '0;
      col_d = '0;
    end else if (xfer) begin
      if (col_q == RC_W'(N - 1) || (TRI_ONLY != 0 && col_q == row_q)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign last_d = (row_d == RC_W'(N - 1)) && (col_d == RC_W'(N - 1));

  matrix_elem_mux #(.N(N), .W(W), .RC_W(RC_W)) u_mux (
    .real_buf_i (real_buf_q),
    .imag_buf_i (imag_buf_q),
    .row_i      (row_d),
    .col_i      (col_d),
    .real_o     (mux_real),
    .imag_o     (mux_imag)
  );

  // On the accepting edge the buffer is still loading, so element (0,0) comes straight off the bus.
  assign real_d   = accept ? bus.real_in[W-1:0] : mux_real;
  assign sel_imag = accept ? bus.imag_in[W-1:0] : mux_imag;
  assign imag_d   = (CONJ != 0) ? W'(sat_neg({{(64-W){sel_imag[W-1]}}, sel_imag}, W)) : sel_imag;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      real_q      <= '0;
      imag_q      <= '0;
      // NOTE: the matrix buffer is reset too, so a discarded partial matrix can never leak out.
      real_buf_q  <= '0;
      imag_buf_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            real_buf_q  <= bus.real_in;
            imag_buf_q  <= bus.imag_in;
            in_ready_q  <= 1'b0;
            state_q     <= STREAM;
            out_valid_q <= 1'b1;
            row_q       <= row_d;
            col_q       <= col_d;
            real_q      <= real_d;
            imag_q      <= imag_d;
            out_last_q  <= last_d;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= IDLE;
            end else begin
              row_q      <= row_d;
              col_q      <= col_d;
              real_q     <= real_d;
              imag_q     <= imag_d;
              out_last_q <= last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_real  = real_q;
  assign bus.out_imag  = imag_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Directed bench for matrix_stream_tx: full, lower-triangle and conjugating instances share one stimulus.
module tb_matrix_stream_tx;
  import matrix_pkg::*;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int NN = N * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid  = 1'b0;
  logic            out_ready = 1'b0;
  logic [NN*W-1:0] real_in   = '0;
  logic [NN*W-1:0] imag_in   = '0;

  matrix_stream_tx_if #(.N(N), .W(W)) if_a(), if_t(), if_c();

  assign if_a.in_valid = in_valid;  assign if_a.out_ready = out_ready;
  assign if_a.real_in  = real_in;   assign if_a.imag_in   = imag_in;
  assign if_t.in_valid = in_valid;  assign if_t.out_ready = out_ready;
  assign if_t.real_in  = real_in;   assign if_t.imag_in   = imag_in;
  assign if_c.in_valid = in_valid;  assign if_c.out_ready = out_ready;
  assign if_c.real_in  = real_in;   assign if_c.imag_in   = imag_in;

  matrix_stream_tx #(.N(N), .W(W), .TRI_ONLY(0), .CONJ(0)) u_full (.clk(clk), .rst(rst), .bus(if_a));
  matrix_stream_tx #(.N(N), .W(W), .TRI_ONLY(1), .CONJ(0)) u_tri  (.clk(clk), .rst(rst), .bus(if_t));
  matrix_stream_tx #(.N(N), .W(W), .TRI_ONLY(0), .CONJ(1)) u_conj (.clk(clk), .rst(rst), .bus(if_c));

  // Observed instance: 0 = full, 1 = triangle, 2 = conjugate.
  int sel = 0;
  logic [73:0] obs_a, obs_t, obs_c, obs;
  assign obs_a = {if_a.out_valid, if_a.in_ready, if_a.busy, if_a.out_last,
                  if_a.out_row, if_a.out_col, if_a.out_real, if_a.out_imag};
  assign obs_t = {if_t.out_valid, if_t.in_ready, if_t.busy, if_t.out_last,
                  if_t.out_row, if_t.out_col, if_t.out_real, if_t.out_imag};
  assign obs_c = {if_c.out_valid, if_c.in_ready, if_c.busy, if_c.out_last,
                  if_c.out_row, if_c.out_col, if_c.out_real, if_c.out_imag};
  assign obs   = (sel == 1) ? obs_t : (sel == 2) ? obs_c : obs_a;

  logic o_valid, o_ready_in, o_busy, o_last;
  logic [2:0]  o_row, o_col;
  logic [31:0] o_real, o_imag;
  assign {o_valid, o_ready_in, o_busy, o_last, o_row, o_col, o_real, o_imag} = obs;

  typedef struct {
    logic [2:0]  row;
    logic [2:0]  col;
    logic [31:0] re;
    logic [31:0] im;
    logic        last;
  } beat_t;
  beat_t beats[$];

  typedef struct {
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic [31:0] exp_re;
    logic [31:0] exp_im;
  } conj_vec_t;

  typedef struct {
    logic [2:0]  exp_row;
    logic [2:0]  exp_col;
    logic [31:0] exp_re;
  } tri_vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", o_valid, 1'b0);
    check("rst_in_ready", o_ready_in, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_last", o_last, 1'b0);
    check("rst_rowcol", {o_row, o_col}, 6'd0);
    check("rst_data", {o_real, o_imag}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_ready", o_ready_in, 1'b1);
  endtask

  task automatic load_matrix(input int kind);
    for (int k = 0; k < NN; k++) begin
      real_in[k*W +: W] = (kind == 0) ? 32'(k) : 32'(100 + k);
      imag_in[k*W +: W] = (kind == 0) ? 32'(1000 + k) : 32'(2000 + k);
    end
  endtask

  // Presents the matrix until accepted; returns at the sample point after the accepting edge.
  task automatic send(input bit hold);
    int n;
    n = 0;
    in_valid = 1'b1;
    while (!o_ready_in && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_ready", o_ready_in, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    check("accept_lat_valid", o_valid, 1'b1);
    check("accept_lat_rowcol", {o_row, o_col}, 6'd0);
    check("accept_busy", o_busy, 1'b1);
  endtask

  // Records every transferred beat until out_last transfers; optional 1,0,0 ready pattern.
  task automatic collect(input bit toggle, input int max_cycles);
    int          cyc;
    bit          done, prev_hold;
    logic [63:0] prev_data;
    logic [7:0]  prev_idx;
    beats.delete();
    cyc = 0;
    done = 0;
    prev_hold = 0;
    prev_data = '0;
    prev_idx = '0;
    while (!done && cyc < max_cycles) begin
      out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (prev_hold) begin
        check("hold_data", {o_real, o_imag}, prev_data);
        check("hold_ctrl", {o_valid, o_last, o_row, o_col}, prev_idx);
      end
      if (o_valid && out_ready) begin
        beats.push_back('{row: o_row, col: o_col, re: o_real, im: o_imag, last: o_last});
        if (o_last) done = 1;
      end
      prev_hold = o_valid && !out_ready;
      prev_data = {o_real, o_imag};
      prev_idx  = {o_valid, o_last, o_row, o_col};
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("collect_done", done, 1'b1);
  endtask

  task automatic check_full(input int base_re, input int base_im);
    check("beat_count", beats.size(), 64'd64);
    for (int k = 0; k < beats.size() && k < NN; k++) begin
      check("beat_real", beats[k].re, 32'(base_re + k));
      check("beat_imag", beats[k].im, 32'(base_im + k));
      check("beat_rowcol", {beats[k].row, beats[k].col}, {3'(k / N), 3'(k % N)});
      check("beat_last", beats[k].last, (k == NN - 1));
    end
  endtask

  conj_vec_t conj_tbl[4];
  tri_vec_t  tri_tbl[5];

  initial begin
    conj_tbl[0] = '{in_re: 32'd11,         in_im: 32'h8000_0000, exp_re: 32'd11,         exp_im: 32'h7FFF_FFFF};
    conj_tbl[1] = '{in_re: 32'hFFFF_FFFD,  in_im: 32'd5,         exp_re: 32'hFFFF_FFFD,  exp_im: 32'hFFFF_FFFB};
    conj_tbl[2] = '{in_re: 32'd7,          in_im: 32'hFFFF_FFF9, exp_re: 32'd7,          exp_im: 32'd7};
    conj_tbl[3] = '{in_re: 32'h7FFF_FFFF,  in_im: 32'd0,         exp_re: 32'h7FFF_FFFF,  exp_im: 32'd0};

    tri_tbl[0] = '{exp_row: 3'd0, exp_col: 3'd0, exp_re: 32'd0};
    tri_tbl[1] = '{exp_row: 3'd1, exp_col: 3'd0, exp_re: 32'd8};
    tri_tbl[2] = '{exp_row: 3'd1, exp_col: 3'd1, exp_re: 32'd9};
    tri_tbl[3] = '{exp_row: 3'd2, exp_col: 3'd0, exp_re: 32'd16};
    tri_tbl[4] = '{exp_row: 3'd2, exp_col: 3'd1, exp_re: 32'd17};

    // Full matrix, ready held high, bubble before in_ready returns.
    sel = 0;
    do_reset();
    load_matrix(0);
    send(0);
    collect(0, 300);
    check_full(0, 1000);
    check("bubble_valid", o_valid, 1'b0);
    check("bubble_in_ready", o_ready_in, 1'b0);
    @(posedge clk);
    #1;
    check("idle_in_ready", o_ready_in, 1'b1);
    check("idle_busy", o_busy, 1'b0);

    // Same matrix with back-pressure.
    do_reset();
    send(0);
    collect(1, 600);
    check_full(0, 1000);

    // Lower triangle only.
    sel = 1;
    do_reset();
    send(0);
    collect(0, 300);
    check("tri_count", beats.size(), 64'd36);
    for (int i = 0; i < 5; i++) begin
      check("tri_tbl_rowcol", {beats[i].row, beats[i].col}, {tri_tbl[i].exp_row, tri_tbl[i].exp_col});
      check("tri_tbl_real", beats[i].re, tri_tbl[i].exp_re);
    end
    begin
      int j;
      j = 0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c <= r; c++) begin
          if (j < beats.size()) begin
            check("tri_rowcol", {beats[j].row, beats[j].col}, {3'(r), 3'(c)});
            check("tri_real", beats[j].re, 32'(r * N + c));
            check("tri_last", beats[j].last, (r == N - 1 && c == N - 1));
          end
          j++;
        end
      end
    end

    // Conjugate with saturation.
    sel = 2;
    do_reset();
    load_matrix(0);
    for (int i = 0; i < 4; i++) begin
      real_in[i*W +: W] = conj_tbl[i].in_re;
      imag_in[i*W +: W] = conj_tbl[i].in_im;
    end
    send(0);
    collect(0, 300);
    check("conj_count", beats.size(), 64'd64);
    for (int i = 0; i < 4; i++) begin
      check("conj_real", beats[i].re, conj_tbl[i].exp_re);
      check("conj_imag", beats[i].im, conj_tbl[i].exp_im);
    end
    check("conj_imag_10", beats[10].im, 32'hFFFF_FC0E);
    check("conj_real_10", beats[10].re, 32'd10);

    // in_valid held high across two matrices; the second bus value must not be captured early.
    sel = 0;
    do_reset();
    load_matrix(0);
    send(1);
    load_matrix(1);
    collect(0, 300);
    check_full(0, 1000);
    check("b2b_bubble_valid", o_valid, 1'b0);
    check("b2b_bubble_ready", o_ready_in, 1'b0);
    @(posedge clk);
    #1;
    check("b2b_ready", o_ready_in, 1'b1);
    check("b2b_not_yet_valid", o_valid, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_second_valid", o_valid, 1'b1);
    check("b2b_second_real", o_real, 32'd100);
    check("b2b_second_busy", o_busy, 1'b1);
    collect(0, 300);
    check_full(100, 2000);

    // Asynchronous reset in the middle of a matrix.
    do_reset();
    load_matrix(0);
    send(0);
    out_ready = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check("mid_beat20_real", o_real, 32'd20);
    check("mid_beat20_rowcol", {o_row, o_col}, {3'd2, 3'd4});
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", o_valid, 1'b0);
    check("async_busy", o_busy, 1'b0);
    check("async_last", o_last, 1'b0);
    check("async_data", {o_real, o_imag}, 64'd0);
    check("async_rowcol", {o_row, o_col}, 6'd0);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("in_rst_ready", o_ready_in, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", o_ready_in, 1'b1);
    check("post_rst_valid", o_valid, 1'b0);
    load_matrix(1);
    send(0);
    check("restart_real", o_real, 32'd100);
    collect(0, 300);
    check_full(100, 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d errors", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_stream_tx.md
Name: matrix_stream_tx

Overview:
- Transmit side of the packed-matrix interface used between the Cholesky inverse stages.
- Accepts one packed N x N complex matrix per transfer and streams it out one element per beat on a valid/ready stream.
- Sits after the transpose stage and feeds element-serial consumers such as the multiplier array and the output DMA.
- Can optionally conjugate elements (Hermitian output) and skip the strictly-upper triangle.

Parameters:
- N, 8, matrix dimension; N*N elements per matrix.
- W, 32, signed element width for the real and imaginary parts.
- TRI_ONLY, 0, 1 = stream only elements with col <= row (N*(N+1)/2 beats); 0 = all N*N beats.
- CONJ, 0, 1 = output the negated imaginary part (saturating).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  packed matrix present on real_in/imag_in.
- in_ready  out  1  block can accept a matrix.
- real_in  in  N*N*W  element k = r*N+c occupies bits [(k+1)*W-1 -: W], signed.
- imag_in  in  N*N*W  same packing as real_in.
- out_valid  out  1  element beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_real  out  W  element real part.
- out_imag  out  W  element imaginary part (conjugated if CONJ).
- out_row  out  $clog2(N)  row index of the current beat.
- out_col  out  $clog2(N)  column index of the current beat.
- out_last  out  1  final beat of the matrix.
- busy  out  1  a matrix is held (state != IDLE).

Behaviour:
- Reset values: in_ready=0 while rst is asserted and 1 from the first clk edge after release; out_valid=0, out_real=0, out_imag=0, out_row=0, out_col=0, out_last=0, busy=0; matrix buffer cleared; state=IDLE.
- States:
  - IDLE: in_ready=1. When in_valid=1, capture both buses into the internal buffer, set row=0 and col=0, and go to STREAM.
  - STREAM: in_ready=0.
- Accept latency: out_valid asserts on the cycle after the accepting edge, presenting element (0,0). Outputs are registered.
- Handshake:
  - A beat transfers on a clk edge with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - out_valid never drops without a transfer.
- Beat order is row-major.
  - After a transfer: col+1; at col=N-1, or at col=row when TRI_ONLY=1, set col=0 and row+1.
  - The next element is registered on the same edge, so back-to-back beats run at 1 per cycle with out_ready held high.
- out_last=1 exactly on the beat (N-1,N-1).
  - On its transfer, out_valid=0 and the state returns to IDLE on that edge.
  - in_ready=1 on the following cycle. There is one bubble cycle between matrices; this is deliberate and there is no input overlap.
- in_valid while in STREAM is ignored: no capture and no error. The upstream holds in_valid until in_ready.
- CONJ=1: out_imag = -imag. The most-negative value -2^(W-1) saturates to 2^(W-1)-1. out_real passes unchanged.
- Beat counts per matrix: TRI_ONLY=0 gives N*N (64); TRI_ONLY=1 gives N*(N+1)/2 (36).
- rst asserted mid-stream: immediate return to all reset values; the partial matrix is discarded; no out_last.
- out_ready may be high while out_valid=0; this has no effect.

Decomposition:
- Shared package matrix_pkg:
  - Element width constant and dimension constant (8).
  - Packed-index helper function (r,c) -> bit offset.
  - Saturating-negate function.
  - State enum {IDLE, STREAM}.
- One sub-module, matrix_elem_mux: combinational N*N-to-1 element select on {row,col} from the buffer, returning the real/imag pair. This keeps the FSM file small.
- The FSM, index counters and output registers stay in matrix_stream_tx.

Test Plan:
1. Reset, then a matrix with real[k]=k and imag[k]=1000+k, out_ready=1 constantly (N=8, TRI_ONLY=0, CONJ=0):
   - 64 consecutive beats with real 0..63 and row/col matching k.
   - out_last only on real=63.
   - in_ready back to 1 exactly 1 cycle after the last transfer.
2. Same matrix with out_ready toggling 1,0,0,1,...:
   - Beats hold stable during the 0 cycles.
   - The sequence still contains 64 beats in order, with no duplicates or drops.
3. TRI_ONLY=1:
   - 36 beats; the sequence begins (0,0),(1,0),(1,1),(2,0), etc.
   - The last beat is (7,7) with real=63 and out_last=1.
4. CONJ=1 with imag[0]=-2147483648, imag[1]=5, imag[2]=-7:
   - out_imag = 2147483647, -5, 7.
   - Real parts unchanged.
5. in_valid held high continuously with two distinct matrices:
   - The second is captured only after the first's out_last transfer plus 1 cycle.
   - No in_valid pulses are accepted during STREAM.
6. Assert rst at beat 20 for one cycle:
   - out_valid=0 and busy=0 immediately (asynchronous).
   - in_ready=1 after release.
   - A new matrix restarts at (0,0).
